// File: rtl/byte_sub_shift_row_if.sv
// Block-level start/done handshake plus the dual-port state RAM bus used by byte_sub_shift_row.
interface byte_sub_shift_row_if;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [4:0]  statemt_address0;
    logic        statemt_ce0;
    logic        statemt_we0;
    logic [31:0] statemt_d0;
    logic [31:0] statemt_q0;
    logic [4:0]  statemt_address1;
    logic        statemt_ce1;
    logic        statemt_we1;
    logic [31:0] statemt_d1;
    logic [31:0] statemt_q1;

    modport slave (
        input  ap_start,
        input  statemt_q0,
        input  statemt_q1,
        output ap_done,
        output ap_idle,
        output ap_ready,
        output statemt_address0,
        output statemt_ce0,
        output statemt_we0,
        output statemt_d0,
        output statemt_address1,
        output statemt_ce1,
        output statemt_we1,
        output statemt_d1
    );

    modport master (
        output ap_start,
        output statemt_q0,
        output statemt_q1,
        input  ap_done,
        input  ap_idle,
        input  ap_ready,
        input  statemt_address0,
        input  statemt_ce0,
        input  statemt_we0,
        input  statemt_d0,
        input  statemt_address1,
        input  statemt_ce1,
        input  statemt_we1,
        input  statemt_d1
    );
endinterface

// File: rtl/byte_sub_shift_row.sv
// AES SubBytes + ShiftRows over a 4x4 byte state held in an external dual-port RAM,
// processed one row per pass: read four columns, substitute, write back rotated.
module byte_sub_shift_row #(
    parameter int NB = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    byte_sub_shift_row_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_CAP,
        S_WR0,
        S_WR1,
        S_DONE
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_row;
    logic [NB-1:0][7:0]   r_b;
    logic [7:0]           r_sbox0;
    logic [7:0]           r_sbox1;
    logic [7:0]           w_sbox_addr0;
    logic [7:0]           w_sbox_addr1;
    logic [NB-1:0][7:0]   w_col_byte;
    logic                 w_unused_q;

    assign w_unused_q = ^{bus.statemt_q0[31:8], bus.statemt_q1[31:8]};

    // Column c of the current row receives the substituted byte read from column (c + row) mod 4.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_col_sel
            assign w_col_byte[gi] = r_b[2'(gi) + r_row];
        end
    endgenerate

    always_ff @(posedge ap_clk) begin
        r_sbox0 <= SBOX[w_sbox_addr0];
        r_sbox1 <= SBOX[w_sbox_addr1];
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.ap_start) w_state_next = S_RD0;
            S_RD0:   w_state_next = S_RD1;
            S_RD1:   w_state_next = S_RD2;
            S_RD2:   w_state_next = S_CAP;
            S_CAP:   w_state_next = S_WR0;
            S_WR0:   w_state_next = S_WR1;
            S_WR1:   w_state_next = (r_row == 2'd3) ? S_DONE : S_RD0;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_row <= '0;
            r_b   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.ap_start) r_row <= '0;
                S_RD2: begin
                    r_b[0] <= r_sbox0;
                    r_b[1] <= r_sbox1;
                end
                S_CAP: begin
                    r_b[2] <= r_sbox0;
                    r_b[3] <= r_sbox1;
                end
                S_WR1: if (r_row != 2'd3) r_row <= r_row + 2'd1;
                default: ;
            endcase
        end
    end

    // Word address is {column, row}; the state never reaches words 16..31.
    always_comb begin
        bus.ap_done          = 1'b0;
        bus.ap_ready         = 1'b0;
        bus.ap_idle          = 1'b0;
        bus.statemt_ce0      = 1'b0;
        bus.statemt_ce1      = 1'b0;
        bus.statemt_we0      = 1'b0;
        bus.statemt_we1      = 1'b0;
        bus.statemt_address0 = '0;
        bus.statemt_address1 = '0;
        bus.statemt_d0       = '0;
        bus.statemt_d1       = '0;
        w_sbox_addr0         = '0;
        w_sbox_addr1         = '0;
        case (r_state)
            S_IDLE: bus.ap_idle = ~bus.ap_start;
            S_RD0: begin
                bus.statemt_ce0      = 1'b1;
                bus.statemt_ce1      = 1'b1;
                bus.statemt_address0 = {1'b0, 2'd0, r_row};
                bus.statemt_address1 = {1'b0, 2'd1, r_row};
            end
            S_RD1: begin
                bus.statemt_ce0      = 1'b1;
                bus.statemt_ce1      = 1'b1;
                bus.statemt_address0 = {1'b0, 2'd2, r_row};
                bus.statemt_address1 = {1'b0, 2'd3, r_row};
                w_sbox_addr0         = bus.statemt_q0[7:0];
                w_sbox_addr1         = bus.statemt_q1[7:0];
            end
            S_RD2: begin
                w_sbox_addr0 = bus.statemt_q0[7:0];
                w_sbox_addr1 = bus.statemt_q1[7:0];
            end
            S_WR0: begin
                bus.statemt_ce0      = 1'b1;
                bus.statemt_ce1      = 1'b1;
                bus.statemt_we0      = 1'b1;
                bus.statemt_we1      = 1'b1;
                bus.statemt_address0 = {1'b0, 2'd0, r_row};
                bus.statemt_address1 = {1'b0, 2'd1, r_row};
                bus.statemt_d0       = {24'h0, w_col_byte[0]};
                bus.statemt_d1       = {24'h0, w_col_byte[1]};
            end
            S_WR1: begin
                bus.statemt_ce0      = 1'b1;
                bus.statemt_ce1      = 1'b1;
                bus.statemt_we0      = 1'b1;
                bus.statemt_we1      = 1'b1;
                bus.statemt_address0 = {1'b0, 2'd2, r_row};
                bus.statemt_address1 = {1'b0, 2'd3, r_row};
                bus.statemt_d0       = {24'h0, w_col_byte[2]};
                bus.statemt_d1       = {24'h0, w_col_byte[3]};
            end
            S_DONE: begin
                bus.ap_done  = 1'b1;
                bus.ap_ready = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_byte_sub_shift_row.sv
// Directed bench for byte_sub_shift_row: RAM model, GF(2^8)-derived S-box reference and a per-cycle output check.
`timescale 1ns/1ps
module tb_byte_sub_shift_row;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    byte_sub_shift_row_if bus();

    byte_sub_shift_row #(.NB(4)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sbox_m [256];
    logic [31:0] mem [32];
    logic [31:0] pre [16];
    logic        pl_we = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          n_high_addr = 0;
    bit          chk_en = 1'b0;
    int          done_cnt, done_first, done_last;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // S-box reference from first principles: multiplicative inverse in GF(2^8) then the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Dual-port state RAM with one-cycle read latency, plus a bench preload port.
    always @(posedge ap_clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        n_high_addr <= n_high_addr + int'(bus.statemt_ce0 && bus.statemt_address0 > 5'd15)
                                   + int'(bus.statemt_ce1 && bus.statemt_address1 > 5'd15);
        if (bus.statemt_ce0) begin
            if (bus.statemt_we0) mem[bus.statemt_address0] <= bus.statemt_d0;
            else                 bus.statemt_q0 <= mem[bus.statemt_address0];
        end
        if (bus.statemt_ce1) begin
            if (bus.statemt_we1) mem[bus.statemt_address1] <= bus.statemt_d1;
            else                 bus.statemt_q1 <= mem[bus.statemt_address1];
        end
    end

    // Run timeline: -1 when idle, else the cycle index since the start was accepted (1..25).
    int          m_t = -1;
    logic [31:0] m_old [16];

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            m_t = -1;
        end else if (m_t < 0) begin
            if (bus.ap_start) begin
                for (int k = 0; k < 16; k++) m_old[k] = mem[k];
                m_t = 1;
            end
        end else if (m_t < 25) begin
            m_t = m_t + 1;
        end else begin
            m_t = -1;
        end
    end

    function automatic logic [7:0] new_byte(input int c, input int r);
        logic [31:0] w = m_old[((c + r) % 4) * 4 + r];
        return sbox_m[w[7:0]];
    endfunction

    function automatic logic [80:0] exp_outputs();
        logic        done = 1'b0, idle = 1'b0, ready = 1'b0;
        logic        ce = 1'b0, we = 1'b0;
        logic [4:0]  a0 = '0, a1 = '0;
        logic [31:0] d0 = '0, d1 = '0;
        int          ph, row, col;
        if (m_t < 0) begin
            idle = !bus.ap_start;
        end else if (m_t == 25) begin
            done  = 1'b1;
            ready = 1'b1;
        end else begin
            ph  = (m_t - 1) % 6;
            row = (m_t - 1) / 6;
            if (ph == 0 || ph == 1 || ph == 4 || ph == 5) begin
                ce  = 1'b1;
                we  = (ph >= 4);
                col = (ph == 0 || ph == 4) ? 0 : 2;
                a0  = 5'(col * 4 + row);
                a1  = 5'((col + 1) * 4 + row);
                if (we) begin
                    d0 = {24'h0, new_byte(col, row)};
                    d1 = {24'h0, new_byte(col + 1, row)};
                end
            end
        end
        return {done, idle, ready, ce, ce, we, we, a0, a1, d0, d1};
    endfunction

    always @(negedge ap_clk) begin
        if (chk_en)
            chk("cycle_outputs",
                96'({bus.ap_done, bus.ap_idle, bus.ap_ready, bus.statemt_ce0, bus.statemt_ce1,
                     bus.statemt_we0, bus.statemt_we1, bus.statemt_address0, bus.statemt_address1,
                     bus.statemt_d0, bus.statemt_d1}),
                96'(exp_outputs()));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic pl_word(input int k, input logic [31:0] v);
        pl_we   = 1'b1;
        pl_addr = 5'(k);
        pl_data = v;
        tick(1);
        pl_we   = 1'b0;
    endtask

    task automatic load_state(input int kind);
        logic [31:0] v;
        for (int k = 0; k < 16; k++) begin
            case (kind)
                0:       v = 32'h0;
                1:       v = 32'(k);
                2:       v = (k == 0) ? 32'hDEADBE53 : 32'h0;
                default: v = $urandom;
            endcase
            pl_word(k, v);
        end
        for (int k = 0; k < 16; k++) pre[k] = mem[k];
    endtask

    // Starts a run and observes ap_done for ncyc cycles; optional start pulse or held start.
    task automatic run_obs(input int ncyc, input int pulse_at, input bit hold);
        bus.ap_start = 1'b1;
        tick(1);
        if (!hold) bus.ap_start = 1'b0;
        done_cnt = 0; done_first = -1; done_last = -1;
        for (int t = 1; t <= ncyc; t++) begin
            if (t == pulse_at)     bus.ap_start = 1'b1;
            if (t == pulse_at + 3) bus.ap_start = 1'b0;
            if (bus.ap_done) begin
                done_cnt++;
                if (done_first < 0) done_first = t;
                done_last = t;
            end
            if (t == ncyc) bus.ap_start = 1'b0;
            else           tick(1);
        end
        tick(1);
    endtask

    task automatic check_model_mem(input string tag);
        logic [31:0] src;
        for (int k = 0; k < 16; k++) begin
            src = pre[(((k / 4) + (k % 4)) % 4) * 4 + (k % 4)];
            chk($sformatf("%s_word%0d", tag, k), 96'(mem[k]), 96'({24'h0, sbox_m[src[7:0]]}));
        end
    endtask

    task automatic check_high_words();
        int nbad = 0;
        for (int k = 16; k < 32; k++)
            if (mem[k] !== (32'hA5A50000 | 32'(k))) nbad++;
        chk("high_words_intact", 96'(nbad), 96'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ap_start = 1'b0;
        for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
        chk("sbox_pin_00", 96'(sbox_m[8'h00]), 96'(8'h63));
        chk("sbox_pin_05", 96'(sbox_m[8'h05]), 96'(8'h6B));
        chk("sbox_pin_0f", 96'(sbox_m[8'h0F]), 96'(8'h76));
        chk("sbox_pin_53", 96'(sbox_m[8'h53]), 96'(8'hED));
        chk("sbox_pin_63", 96'(sbox_m[8'h63]), 96'(8'hFB));

        // Reset behaviour, with and without ap_start.
        tick(1);
        chk_en = 1'b1;
        tick(2);
        chk("rst_idle", 96'(bus.ap_idle), 96'(1));
        chk("rst_ce_we", 96'({bus.statemt_ce0, bus.statemt_ce1, bus.statemt_we0, bus.statemt_we1}), 96'(0));
        bus.ap_start = 1'b1;
        tick(2);
        chk("rst_idle_start_high", 96'(bus.ap_idle), 96'(0));
        bus.ap_start = 1'b0;
        tick(1);
        ap_rst = 1'b0;
        tick(2);
        for (int k = 16; k < 32; k++) pl_word(k, 32'hA5A50000 | 32'(k));

        load_state(0);
        run_obs(25, -10, 1'b0);
        chk("zero_latency", 96'(done_first), 96'(25));
        for (int k = 0; k < 16; k++) chk($sformatf("zero_word%0d", k), 96'(mem[k]), 96'(32'h63));
        $display("run zero_state done_at=%0d", done_first);

        load_state(1);
        run_obs(25, -10, 1'b0);
        chk("ramp_word0", 96'(mem[0]), 96'(32'h63));
        chk("ramp_word1", 96'(mem[1]), 96'(32'h6B));
        chk("ramp_word2", 96'(mem[2]), 96'(32'h67));
        chk("ramp_word3", 96'(mem[3]), 96'(32'h76));
        check_model_mem("ramp");
        $display("run ramp_state done_at=%0d", done_first);

        load_state(2);
        run_obs(25, -10, 1'b0);
        chk("dead_word0", 96'(mem[0]), 96'(32'hED));
        check_model_mem("dead");
        check_high_words();
        $display("run deadbe53_state done_at=%0d", done_first);

        for (int n = 0; n < 2; n++) begin
            load_state(3);
            run_obs(25, -10, 1'b0);
            chk("rand_latency", 96'(done_first), 96'(25));
            check_model_mem($sformatf("rand%0d", n));
            $display("run random_state_%0d done_at=%0d", n, done_first);
        end

        // Abort during row 1 (cycle 10): row 0 rewritten, rows 1..3 untouched.
        load_state(1);
        bus.ap_start = 1'b1;
        tick(1);
        bus.ap_start = 1'b0;
        tick(9);
        ap_rst = 1'b1;
        #1;
        chk("abort_outputs_zero",
            96'({bus.ap_done, bus.ap_ready, bus.statemt_ce0, bus.statemt_ce1, bus.statemt_we0,
                 bus.statemt_we1, bus.statemt_address0, bus.statemt_address1, bus.statemt_d0, bus.statemt_d1}),
            96'(0));
        chk("abort_idle", 96'(bus.ap_idle), 96'(1));
        tick(2);
        ap_rst = 1'b0;
        tick(2);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] want;
            case (k)
                0:       want = 32'h63;
                4:       want = 32'hF2;
                8:       want = 32'h30;
                12:      want = 32'hFE;
                default: want = 32'(k);
            endcase
            chk($sformatf("abort_word%0d", k), 96'(mem[k]), 96'(want));
        end
        $display("run reset_abort at cycle 10");

        load_state(0);
        run_obs(51, -10, 1'b1);
        chk("held_done_count", 96'(done_cnt), 96'(2));
        chk("held_first_done", 96'(done_first), 96'(25));
        chk("held_second_done", 96'(done_last), 96'(51));
        for (int k = 0; k < 16; k++) chk($sformatf("held_word%0d", k), 96'(mem[k]), 96'(32'hFB));
        $display("run start_held done_at=%0d,%0d", done_first, done_last);

        load_state(3);
        run_obs(40, 8, 1'b0);
        chk("pulse_done_count", 96'(done_cnt), 96'(1));
        chk("pulse_done_at", 96'(done_first), 96'(25));
        check_model_mem("pulse");
        $display("run start_pulsed_midrun done_at=%0d count=%0d", done_first, done_cnt);

        tick(2);
        chk("no_high_address", 96'(n_high_addr), 96'(0));
        check_high_words();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/byte_sub_shift_row.md
BYTE_SUB_SHIFT_ROW -- requirements
Module: byte_sub_shift_row

Interface
REQ-001 Parameter NB, default 4, number of state columns; only 4 is supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 ap_clk  in  1  rising-edge clock.
REQ-004 ap_rst  in  1  reset; asynchronous, active-high.
REQ-005 ap_start  in  1  start request; sampled in IDLE only.
REQ-006 ap_done  out  1  one-cycle pulse when the state update is complete.
REQ-007 ap_idle  out  1  high in IDLE while ap_start is low.
REQ-008 ap_ready  out  1  same cycle as ap_done; a new start is accepted next cycle.
REQ-009 statemt_address0 / statemt_address1  out  5  word addresses for state RAM ports 0 and 1.
REQ-010 statemt_ce0 / statemt_ce1  out  1  port enables.
REQ-011 statemt_we0 / statemt_we1  out  1  port write enables.
REQ-012 statemt_d0 / statemt_d1  out  32  write data.
REQ-013 statemt_q0 / statemt_q1  in  32  read data, valid the cycle after ce with we low.

Function
REQ-014 State layout is statemt[c*4+r], column c 0..3, row r 0..3; only words 0..15 are ever addressed.
REQ-015 Only bits [7:0] of each read word are used; written words carry the result in [7:0] with [31:8] zero.
REQ-016 Result: new statemt[c*4+r] = SBOX(old statemt[((c+r) mod 4)*4+r][7:0]), where SBOX is the FIPS-197 forward S-box.
REQ-017 SBOX is an internal 256x8 ROM with two read ports, one-cycle registered read.
REQ-018 FSM states: IDLE, RD0, RD1, RD2, CAP, WR0, WR1, DONE; a 2-bit row counter r; a 4-byte row buffer b[0..3].
REQ-019 IDLE: when ap_start=1, clear r and go to RD0; otherwise stay in IDLE.
REQ-020 RD0: issue reads of c=0 on port 0 and c=1 on port 1 (address c*4+r).
REQ-021 RD1: issue reads of c=2 and c=3; drive SBOX addresses from q0[7:0] and q1[7:0].
REQ-022 RD2: capture the SBOX outputs into b[0] and b[1]; drive SBOX addresses from q0/q1 (c=2, c=3).
REQ-023 CAP: capture the SBOX outputs into b[2] and b[3]; no RAM access.
REQ-024 WR0: write c=0 on port 0 with b[r mod 4] and c=1 on port 1 with b[(1+r) mod 4].
REQ-025 WR1: write c=2 with b[(2+r) mod 4] and c=3 with b[(3+r) mod 4]; if r=3 go to DONE, else increment r and go to RD0.
REQ-026 DONE: assert ap_done and ap_ready for one cycle, then go to IDLE.
REQ-027 Latency: ap_done is high exactly 25 cycles after the cycle in which ap_start is sampled high in IDLE.
REQ-028 ce0/ce1 are high only in RD0, RD1, WR0 and WR1; we0/we1 are high only in WR0 and WR1.
REQ-029 Addresses and write data are zero whenever the corresponding ce is low.
REQ-030 ap_start changes outside IDLE are ignored.
REQ-031 If ap_start is high during DONE, the next run starts on the next cycle only via IDLE, so RD0 follows 2 cycles after DONE.

Reset
REQ-032 ap_rst forces IDLE immediately and clears r and b.
REQ-033 During reset all outputs are 0 except ap_idle, which is 1 if ap_start is 0.
REQ-034 Reset mid-operation aborts without any further write; rows already written stay modified.

Verification
REQ-035 Words 0..15 = 0 -> after ap_done, all 16 words = 0x00000063; ap_done exactly 25 cycles after start.
REQ-036 statemt[k] = k (k = 0..15) -> word0 = 0x63, word1 = 0x6B, word2 = 0x67, word3 = 0x76.
REQ-037 statemt[0] = 0xDEADBE53, others 0 -> word0 = 0x000000ED; words 16..31 are never addressed, and ce is low throughout IDLE.
REQ-038 Reset asserted at cycle 10 after start -> outputs 0 at once; row 0 updated, rows 1..3 unchanged.
REQ-039 ap_start held high, zero state -> two runs complete; all words = 0xFB after the second ap_done.
REQ-040 ap_start pulsed mid-run -> no effect; single ap_done pulse at cycle 25.
